mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, beq, addi and j. It drives the register-file write enable (we3) through regwrite, and it drives the datapath mux selects that choose wa3 and wd3. It also runs a request/ready handshake with the unified instruction/data memory.

---
 rtl/mips_ctrl_pkg.sv | 62 ++++++
 rtl/mips_ctrl_outdec.sv | 91 +++++++++
 rtl/mips_multicycle_ctrl.sv | 110 +++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode and mux-select encodings for the multicycle MIPS control
package mips_ctrl_pkg;

    localparam int OPCODE_W = 6;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_RTYP = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J    = 6'b000010;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Also consumed by the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctrl_t;

    function automatic logic is_supported_op(input logic [OPCODE_W-1:0] opc);
        return (opc == OP_LW) || (opc == OP_SW) || (opc == OP_RTYP) ||
               (opc == OP_BEQ) || (opc == OP_ADDI) || (opc == OP_J);
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// rtl/mips_ctrl_outdec.sv - combinational state-to-control decode for the multicycle MIPS control
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic       zero,
    output ctrl_t      ctrl
);

    logic pcwrite;
    logic branch;

    always_comb begin
        ctrl    = '0;
        pcwrite = 1'b0;
        branch  = 1'b0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b0;
                ctrl.alusrca = 1'b0;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                ctrl.irwrite = mem_ready;
                pcwrite      = mem_ready;
            end
            S_DECODE: begin
                ctrl.alusrca = 1'b0;
                ctrl.alusrcb = SRCB_IMMSH;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b0;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = mem_ready;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                ctrl.memtoreg = 1'b0;
            end
            S_BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                branch       = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b0;
                ctrl.memtoreg = 1'b0;
            end
            S_JEX: begin
                ctrl.pcsrc = PCSRC_JUMP;
                pcwrite    = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
        ctrl.pcen = pcwrite | (branch & zero);
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - main control FSM sequencing the multicycle MIPS datapath
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int OP_W        = OPCODE_W
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            memwrite,
    output logic            iord,
    output logic            irwrite,
    output logic            pcen,
    output logic            regwrite,
    output logic            regdst,
    output logic            memtoreg,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [1:0]      aluop,
    output logic [1:0]      pcsrc,
    output logic            illegal_op,
    output logic [3:0]      state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       mem_rdy;
    logic       illegal_raw;
    ctrl_t      ctrl;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        illegal_raw = 1'b0;
        case (state_q)
            S_FETCH:   state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD:   state_d = mem_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_rdy ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_rdy),
        .zero      (zero),
        .ctrl      (ctrl)
    );

    // Strobes are gated by reset directly so they drop the instant reset_n falls,
    // even though state_q already reads FETCH (which would otherwise request memory).
    assign mem_req    = reset_n & ctrl.mem_req;
    assign memwrite   = reset_n & ctrl.memwrite;
    assign irwrite    = reset_n & ctrl.irwrite;
    assign pcen       = reset_n & ctrl.pcen;
    assign regwrite   = reset_n & ctrl.regwrite;
    assign illegal_op = reset_n & illegal_raw;

    assign iord     = ctrl.iord;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign aluop    = ctrl.aluop;
    assign pcsrc    = ctrl.pcsrc;
    assign state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for the multicycle MIPS control FSM
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       illegal_op;
    logic [3:0] state;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         rw_cnt   = 0;
    logic [5:0] cur_op   = 6'b0;
    bit         cur_illegal = 1'b0;

    // Expected control word per state, mem_ready/zero-qualified bits left clear:
    // {mem_req,memwrite,iord,irwrite,pcen,regwrite,regdst,memtoreg,alusrca,alusrcb,aluop,pcsrc}
    logic [14:0] tbl [0:11];

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .aluop      (aluop),
        .pcsrc      (pcsrc),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit tb_legal(input logic [5:0] o);
        return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
               o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
    endfunction

    // One instruction phase; memory phases repeat while the bench holds mem_ready low.
    task automatic step(input int exp_st, input int zmode, input int fw);
        int          waits;
        bit          done;
        bit          is_mem;
        logic [14:0] exp;
        logic [14:0] got;
        waits  = 0;
        done   = 1'b0;
        is_mem = (exp_st == 0) || (exp_st == 3) || (exp_st == 5);
        while (!done) begin
            @(negedge clk);
            op = (exp_st == 0) ? 6'($urandom) : cur_op;
            if (is_mem && exp_st == 5 && fw >= 0) begin
                mem_ready = (waits >= fw);
            end else if (is_mem) begin
                mem_ready = (waits >= 4) || ($urandom_range(0, 2) != 0);
            end else begin
                mem_ready = 1'($urandom);
            end
            zero = (zmode == 2) ? 1'($urandom) : zmode[0];
            #1;
            exp = tbl[exp_st];
            if (exp_st == 0) begin
                exp[11] = mem_ready;
                exp[10] = mem_ready;
            end
            if (exp_st == 5) exp[13] = mem_ready;
            if (exp_st == 8) exp[10] = zero;
            got = {mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
                   alusrca, alusrcb, aluop, pcsrc};
            chk($sformatf("state_in_%0d", exp_st), 16'(state), 16'(exp_st));
            chk($sformatf("ctrl_in_%0d", exp_st), 16'(got), 16'(exp));
            chk($sformatf("illegal_in_%0d", exp_st), 16'(illegal_op),
                16'(exp_st == 1 && cur_illegal));
            if (regwrite) rw_cnt++;
            if (!is_mem || mem_ready) done = 1'b1;
            else waits++;
        end
    endtask

    task automatic run_instr(input logic [5:0] opc, input int zmode, input int fw);
        int seq[$];
        int exp_rw;
        cur_op      = opc;
        cur_illegal = 1'b0;
        exp_rw      = 0;
        case (opc)
            6'b100011: begin seq = '{0, 1, 2, 3, 4}; exp_rw = 1; end
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: begin seq = '{0, 1, 6, 7}; exp_rw = 1; end
            6'b000100: seq = '{0, 1, 8};
            6'b001000: begin seq = '{0, 1, 9, 10}; exp_rw = 1; end
            6'b000010: seq = '{0, 1, 11};
            default: begin seq = '{0, 1}; cur_illegal = 1'b1; end
        endcase
        rw_cnt = 0;
        foreach (seq[i]) step(seq[i], zmode, fw);
        chk($sformatf("regwrite_pulses_op%b", opc), 16'(rw_cnt), 16'(exp_rw));
    endtask

    initial begin
        logic [5:0] ops [0:5];
        logic [5:0] r;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;

        tbl[0]  = 15'b1_0_0_0_0_0_0_0_0_01_00_00;
        tbl[1]  = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
        tbl[2]  = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
        tbl[3]  = 15'b1_0_1_0_0_0_0_0_0_00_00_00;
        tbl[4]  = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
        tbl[5]  = 15'b1_0_1_0_0_0_0_0_0_00_00_00;
        tbl[6]  = 15'b0_0_0_0_0_0_0_0_1_00_10_00;
        tbl[7]  = 15'b0_0_0_0_0_1_1_0_0_00_00_00;
        tbl[8]  = 15'b0_0_0_0_0_0_0_0_1_00_01_01;
        tbl[9]  = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
        tbl[10] = 15'b0_0_0_0_0_1_0_0_0_00_00_00;
        tbl[11] = 15'b0_0_0_0_1_0_0_0_0_00_00_10;

        reset_n   = 1'b0;
        op        = 6'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #12;
        chk("reset_state", 16'(state), 16'd0);
        chk("reset_mem_req", 16'(mem_req), 16'd0);
        chk("reset_pcen", 16'(pcen), 16'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        reset_n   = 1'b1;
        #1;
        chk("post_reset_mem_req", 16'(mem_req), 16'd1);

        // Reset in the middle of an R-type execute abandons the instruction.
        cur_op = 6'b000000;
        cur_illegal = 1'b0;
        step(0, 2, -1);
        step(1, 2, -1);
        step(6, 2, -1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_state", 16'(state), 16'd0);
        chk("async_reset_regwrite", 16'(regwrite), 16'd0);
        chk("async_reset_mem_req", 16'(mem_req), 16'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        reset_n   = 1'b1;
        #1;
        chk("rerelease_mem_req", 16'(mem_req), 16'd1);
        chk("rerelease_state", 16'(state), 16'd0);

        run_instr(6'b100011, 2, -1);
        run_instr(6'b101011, 2, 3);
        run_instr(6'b000100, 1, -1);
        run_instr(6'b000100, 0, -1);
        run_instr(6'b000000, 2, -1);
        run_instr(6'b001000, 2, -1);
        run_instr(6'b000010, 2, -1);
        run_instr(6'b111111, 2, -1);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = 6'($urandom);
                if (tb_legal(r)) r = 6'b111111;
            end else begin
                r = ops[$urandom_range(0, 5)];
            end
            run_instr(r, 2, -1);
        end
        step(0, 2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
